pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Parametrised program-counter and instruction-fetch unit for the multi-cycle CPU. It holds the PC and issues one fetch per instruction to instruction memory over a req/ack handshake. It latches the returned word into the instruction register and selects the next PC from sequential, branch, jump, register-jump, exception and exception-return sources. It sits between the control FSM (which pulses `pc_en` once per retired instruction) and the instruction memory.

## Interface
- `XLEN`, 32: PC and data width.
- `RESET_PC`, 32'h0000_3000: PC after reset.
- `EXC_PC`, 32'h0000_4180: exception vector.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `pc_en` in 1: advance to the next PC; acted on only in READY.
- `pc_sel` in 2: next-PC source: 00 seq, 01 branch, 10 jump, 11 register-jump.
- `br_taken` in 1: branch condition, used when `pc_sel`=01.
- `bpc`, `jpc`, `rpc` in XLEN: branch, jump and register-jump targets.
- `exc` in 1: take exception; qualified by `pc_en`.
- `eret` in 1: return from exception; qualified by `pc_en`.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: fetch address; always equals `pc`.
- `imem_ack` in 1: fetch complete, `imem_rdata` valid.
- `imem_rdata` in 32: fetched word.
- `ir` out 32: instruction register.
- `ir_valid` out 1: `ir` holds the instruction at `pc`.
- `pc` out XLEN: current PC.
- `pc4` out XLEN: `pc`+4, combinational.
- `epc` out XLEN: saved exception PC.
- `misalign` out 1: one-cycle pulse on a misaligned redirect.

## Operation
- Reset values:
  - `pc`=RESET_PC, `epc`=0, `ir`=0, `ir_valid`=0, `misalign`=0.
  - State=FETCH, so `imem_req`=1 in the first cycle after reset.
- FETCH state:
  - `imem_req`=1; `imem_addr` stays stable until ack.
  - On `imem_ack`: `ir`<=`imem_rdata`, `ir_valid`<=1, go to READY.
  - `pc_en`, `exc` and `eret` are ignored in FETCH.
- READY state:
  - `imem_req`=0 and `imem_ack` is ignored.
  - Without `pc_en`, `pc` and `ir` hold. There is no implicit increment.
  - On `pc_en`: `pc`<=next, `ir_valid`<=0, go to FETCH.
- Next-PC priority, highest first:
  - `exc`: next=EXC_PC, `epc`<=`pc`.
  - `eret`: next=`epc`.
  - Otherwise by `pc_sel`:
    - 00: `pc4`.
    - 01: `bpc` if `br_taken`, else `pc4`.
    - 10: `jpc`.
    - 11: `rpc`.
- Misalignment:
  - Applies when the selected redirect target (`bpc`, `jpc`, `rpc` or `epc`) has bits [1:0]≠0.
  - The redirect is handled as an exception: next=EXC_PC, `epc`<=`pc`, `misalign` pulses for one cycle.
  - Sequential `pc4` is never checked.
- Simultaneous `exc` and `eret`: `exc` wins and `epc` is overwritten.
- Arithmetic: `pc4` is computed modulo 2^XLEN, so 0xFFFF_FFFC+4=0.

## Timing
- Minimum fetch latency is one cycle. An ack in the first FETCH cycle gives `ir_valid`=1 on the next edge.
- Wait states: any number of cycles without ack keeps FETCH, `imem_req`=1 and `imem_addr` constant.
- `pc` changes on the edge where `pc_en` is sampled in READY. `imem_addr` shows the new PC in the same cycle that FETCH begins.
- `misalign` is registered and high in the cycle after the redirect edge.
- Reset mid-fetch: on the next edge, `pc`=RESET_PC and state=FETCH. A late `imem_ack` from the aborted fetch that arrives while `reset` is high is dropped. After reset the memory must treat `imem_req` as a new request.

## Structure
- Shared package `pc_fetch_pkg` holds:
  - `pc_sel` encodings `PC_SEL_SEQ`/`BR`/`J`/`JR`.
  - The FSM state enum FETCH/READY.
- Sub-module `pc_next_mux`: combinational priority select plus misalignment detect, producing `next_pc` and `mis`.
- Top module: state register, PC, EPC, IR and handshake.

## Test plan
- Reset, then hold 3 cycles without ack -> `pc`=`imem_addr`=0x3000, `imem_req`=1, `ir_valid`=0, `epc`=0.
- Ack on the 3rd FETCH cycle with `rdata`=0x2008_0005, then `pc_en` with `pc_sel`=00 -> `ir`=0x2008_0005 and `ir_valid`=1; next `pc`=0x3004 with `imem_req`=1. Repeat from a forced `pc`=0xFFFF_FFFC -> `pc`=0.
- `pc_sel`=01, `bpc`=0x3040: with `br_taken`=1 -> `pc`=0x3040; with `br_taken`=0 from 0x3040 -> 0x3044.
- `pc`=0x3010, `exc`+`eret`+`pc_en` -> `pc`=0x4180, `epc`=0x3010. After the fetch, `eret`+`pc_en` -> `pc`=0x3010.
- `pc`=0x3020, `pc_sel`=11, `rpc`=0x3002, `pc_en` -> `pc`=0x4180, `epc`=0x3020, `misalign` high for exactly one cycle.
- `pc_en` pulsed during FETCH -> `pc` unchanged. `reset` asserted with ack pending -> `pc`=0x3000, `ir_valid`=0, and the late ack is ignored.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the program-counter / instruction-fetch unit:
// next-PC source encodings, fetch FSM states and a small alignment helper.
package pc_fetch_pkg;

    // Next-PC source selection carried on pc_sel
    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_J   = 2'b10;
    localparam logic [1:0] PC_SEL_JR  = 2'b11;

    // Fetch FSM: FETCH waits for the memory ack, READY waits for pc_en
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        READY = 1'b1
    } fetch_state_e;

    // True when the low address bits do not describe a word boundary
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: exception > exception-return > pc_sel source.
// A redirect to a target that is not word aligned is turned into an
// exception; the sequential pc+4 path is never checked.
module pc_next_mux
    import pc_fetch_pkg::*;
#(
    parameter int          XLEN   = 32,
    parameter logic [XLEN-1:0] EXC_PC = 32'h0000_4180
) (
    input  logic [XLEN-1:0] pc4,
    input  logic [1:0]      pc_sel,
    input  logic            br_taken,
    input  logic [XLEN-1:0] bpc,
    input  logic [XLEN-1:0] jpc,
    input  logic [XLEN-1:0] rpc,
    input  logic [XLEN-1:0] epc,
    input  logic            exc,
    input  logic            eret,
    output logic [XLEN-1:0] next_pc,
    output logic            mis,
    output logic            take_exc
);

    logic [XLEN-1:0] target_s;
    logic            redirect_s;

    // Pick the candidate target and note whether it is a checked redirect
    always_comb begin
        target_s   = pc4;
        redirect_s = 1'b0;
        if (eret) begin
            target_s   = epc;
            redirect_s = 1'b1;
        end else begin
            case (pc_sel)
                PC_SEL_SEQ: begin
                    target_s   = pc4;
                    redirect_s = 1'b0;
                end
                PC_SEL_BR: begin
                    if (br_taken) begin
                        target_s   = bpc;
                        redirect_s = 1'b1;
                    end else begin
                        target_s   = pc4;
                        redirect_s = 1'b0;
                    end
                end
                PC_SEL_J: begin
                    target_s   = jpc;
                    redirect_s = 1'b1;
                end
                PC_SEL_JR: begin
                    target_s   = rpc;
                    redirect_s = 1'b1;
                end
                default: begin
                    target_s   = pc4;
                    redirect_s = 1'b0;
                end
            endcase
        end
    end

    // Apply exception priority and the misaligned-redirect trap
    always_comb begin
        next_pc  = target_s;
        mis      = 1'b0;
        take_exc = 1'b0;
        if (exc) begin
            next_pc  = EXC_PC;
            take_exc = 1'b1;
        end else if (redirect_s && is_misaligned(target_s[1:0])) begin
            next_pc  = EXC_PC;
            mis      = 1'b1;
            take_exc = 1'b1;
        end else begin
            next_pc  = target_s;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch unit. Issues one fetch per
// instruction over a req/ack handshake, latches the word into IR, and
// advances the PC when the control FSM pulses pc_en in READY.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [XLEN-1:0] EXC_PC   = 32'h0000_4180
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_en,
    input  logic [1:0]      pc_sel,
    input  logic            br_taken,
    input  logic [XLEN-1:0] bpc,
    input  logic [XLEN-1:0] jpc,
    input  logic [XLEN-1:0] rpc,
    input  logic            exc,
    input  logic            eret,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic            ir_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] epc,
    output logic            misalign
);

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    fetch_state_e    state_r;
    fetch_state_e    state_next_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] epc_r;
    logic [31:0]     ir_r;
    logic            ir_valid_r;
    logic            misalign_r;
    logic [XLEN-1:0] pc4_s;
    logic [XLEN-1:0] next_pc_s;
    logic            mis_s;
    logic            take_exc_s;
    logic            advance_s;
    logic            fetch_done_s;

    assign pc4_s        = pc_r + PC_STEP;
    assign advance_s    = (state_r == READY) && pc_en;
    assign fetch_done_s = (state_r == FETCH) && imem_ack;

    pc_next_mux #(
        .XLEN   (XLEN),
        .EXC_PC (EXC_PC)
    ) u_next_mux (
        .pc4      (pc4_s),
        .pc_sel   (pc_sel),
        .br_taken (br_taken),
        .bpc      (bpc),
        .jpc      (jpc),
        .rpc      (rpc),
        .epc      (epc_r),
        .exc      (exc),
        .eret     (eret),
        .next_pc  (next_pc_s),
        .mis      (mis_s),
        .take_exc (take_exc_s)
    );

    // Fetch FSM next-state: wait for ack in FETCH, wait for pc_en in READY
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH: begin
                if (imem_ack) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = FETCH;
                end
            end
            READY: begin
                if (pc_en) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = READY;
                end
            end
            default: state_next_s = FETCH;
        endcase
    end

    // Fetch FSM state register; reset restarts a fresh fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC and saved exception PC, updated only when an instruction retires
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r  <= RESET_PC;
            epc_r <= {XLEN{1'b0}};
        end else if (advance_s) begin
            pc_r <= next_pc_s;
            if (take_exc_s) begin
                epc_r <= pc_r;
            end
        end
    end

    // Instruction register and its valid flag; an ack during reset is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_r       <= 32'h0000_0000;
            ir_valid_r <= 1'b0;
        end else if (fetch_done_s) begin
            ir_r       <= imem_rdata;
            ir_valid_r <= 1'b1;
        end else if (advance_s) begin
            ir_valid_r <= 1'b0;
        end
    end

    // One-cycle pulse after a redirect that trapped on alignment
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= advance_s && mis_s;
        end
    end

    assign imem_req  = (state_r == FETCH);
    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign pc4       = pc4_s;
    assign epc       = epc_r;
    assign ir        = ir_r;
    assign ir_valid  = ir_valid_r;
    assign misalign  = misalign_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the fetch unit.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] VEC_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        br_taken;
    logic [31:0] bpc, jpc, rpc;
    logic        exc, eret;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc, pc4, epc;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit          model_on = 1'b0;
    bit          m_waiting;      // a fetch is outstanding
    logic [31:0] m_pc, m_epc, m_ir;
    bit          m_ir_valid;
    bit          m_mis;

    pc_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .br_taken   (br_taken),
        .bpc        (bpc),
        .jpc        (jpc),
        .rpc        (rpc),
        .exc        (exc),
        .eret       (eret),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .pc4        (pc4),
        .epc        (epc),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        logic [31:0] dest;
        bit          redirect;
        bit          trap;
        if (reset) begin
            m_pc = RST_PC; m_epc = 32'd0; m_ir = 32'd0;
            m_ir_valid = 1'b0; m_mis = 1'b0; m_waiting = 1'b1;
            model_on = 1'b1;
        end else begin
            m_mis = 1'b0;
            if (m_waiting) begin
                if (imem_ack) begin
                    m_ir = imem_rdata; m_ir_valid = 1'b1; m_waiting = 1'b0;
                end
            end else if (pc_en) begin
                dest = m_pc + 32'd4;
                redirect = 1'b0;
                trap = exc;
                if (!exc) begin
                    if (eret) begin
                        dest = m_epc; redirect = 1'b1;
                    end else if (pc_sel == 2'd1 && br_taken) begin
                        dest = bpc; redirect = 1'b1;
                    end else if (pc_sel == 2'd2) begin
                        dest = jpc; redirect = 1'b1;
                    end else if (pc_sel == 2'd3) begin
                        dest = rpc; redirect = 1'b1;
                    end
                    if (redirect && (dest % 4 != 0)) begin
                        trap = 1'b1; m_mis = 1'b1;
                    end
                end
                if (trap) begin
                    m_epc = m_pc; m_pc = VEC_PC;
                end else begin
                    m_pc = dest;
                end
                m_ir_valid = 1'b0;
                m_waiting = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (model_on) begin
            check("pc",        pc,        m_pc);
            check("imem_addr", imem_addr, m_pc);
            check("pc4",       pc4,       m_pc + 32'd4);
            check("epc",       epc,       m_epc);
            check("ir",        ir,        m_ir);
            check("ir_valid",  {31'd0, ir_valid}, {31'd0, m_ir_valid});
            check("imem_req",  {31'd0, imem_req}, {31'd0, m_waiting});
            check("misalign",  {31'd0, misalign}, {31'd0, m_mis});
        end
    end

    task automatic idle_inputs();
        pc_en = 1'b0; exc = 1'b0; eret = 1'b0; imem_ack = 1'b0;
        pc_sel = 2'b00; br_taken = 1'b0;
    endtask

    task automatic do_ack(input logic [31:0] data);
        imem_ack = 1'b1; imem_rdata = data;
        step();
        imem_ack = 1'b0;
    endtask

    task automatic retire(input logic [1:0] sel);
        pc_sel = sel; pc_en = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic jump_to(input logic [31:0] addr);
        jpc = addr;
        retire(2'b10);
        do_ack(32'h1357_9BDF);
    endtask

    initial begin
        reset = 1'b1; idle_inputs();
        bpc = 32'd0; jpc = 32'd0; rpc = 32'd0; imem_rdata = 32'd0;
        step();
        reset = 1'b0;

        // Wait states after reset
        step(); step();
        check("lit_pc_rst",   pc, 32'h0000_3000);
        check("lit_addr_rst", imem_addr, 32'h0000_3000);
        check("lit_req_rst",  {31'd0, imem_req}, 32'd1);
        check("lit_irv_rst",  {31'd0, ir_valid}, 32'd0);
        check("lit_epc_rst",  epc, 32'd0);
        do_ack(32'h2008_0005);
        check("lit_ir",       ir, 32'h2008_0005);
        check("lit_irv",      {31'd0, ir_valid}, 32'd1);
        retire(2'b00);
        check("lit_pc_seq",   pc, 32'h0000_3004);
        check("lit_req_seq",  {31'd0, imem_req}, 32'd1);

        // Wrap-around of the sequential increment
        do_ack(32'h0000_0013);
        jump_to(32'hFFFF_FFFC);
        retire(2'b00);
        check("lit_pc_wrap", pc, 32'h0000_0000);

        // Branch taken / not taken
        do_ack(32'h0000_0013);
        jump_to(32'h0000_3000);
        bpc = 32'h0000_3040; br_taken = 1'b1; pc_sel = 2'b01; pc_en = 1'b1;
        step(); idle_inputs();
        check("lit_br_taken", pc, 32'h0000_3040);
        do_ack(32'h0000_0013);
        br_taken = 1'b0; pc_sel = 2'b01; pc_en = 1'b1;
        step(); idle_inputs();
        check("lit_br_not", pc, 32'h0000_3044);

        // Exception beats eret, then return
        do_ack(32'h0000_0013);
        jump_to(32'h0000_3010);
        exc = 1'b1; eret = 1'b1; pc_en = 1'b1;
        step(); idle_inputs();
        check("lit_exc_pc",  pc,  32'h0000_4180);
        check("lit_exc_epc", epc, 32'h0000_3010);
        do_ack(32'h0000_0013);
        eret = 1'b1; pc_en = 1'b1;
        step(); idle_inputs();
        check("lit_eret_pc", pc, 32'h0000_3010);

        // Misaligned register jump
        do_ack(32'h0000_0013);
        jump_to(32'h0000_3020);
        rpc = 32'h0000_3002;
        retire(2'b11);
        check("lit_mis_pc",  pc,  32'h0000_4180);
        check("lit_mis_epc", epc, 32'h0000_3020);
        check("lit_mis_hi",  {31'd0, misalign}, 32'd1);
        step();
        check("lit_mis_lo",  {31'd0, misalign}, 32'd0);

        // pc_en during FETCH is ignored
        pc_en = 1'b1; pc_sel = 2'b10; jpc = 32'h0000_5000;
        step(); idle_inputs();
        check("lit_fetch_hold", pc, 32'h0000_4180);

        // Reset with an ack arriving at the same time
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        reset = 1'b0; imem_ack = 1'b0;
        check("lit_rst_pc",  pc, 32'h0000_3000);
        check("lit_rst_irv", {31'd0, ir_valid}, 32'd0);
        check("lit_rst_ir",  ir, 32'd0);
        check("lit_rst_req", {31'd0, imem_req}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            pc_en      = $urandom_range(0, 1);
            imem_ack   = ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            pc_sel     = 2'($urandom_range(0, 3));
            br_taken   = $urandom_range(0, 1);
            exc        = ($urandom_range(0, 7) == 0);
            eret       = ($urandom_range(0, 5) == 0);
            bpc        = $urandom; jpc = $urandom; rpc = $urandom;
            if ($urandom_range(0, 5) != 0) bpc[1:0] = 2'b00;
            if ($urandom_range(0, 5) != 0) jpc[1:0] = 2'b00;
            if ($urandom_range(0, 5) != 0) rpc[1:0] = 2'b00;
            step();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
